// File: rtl/lcd_write_ctrl.sv
// HD44780 write sequencer: queues CPU stores in a 4-entry FIFO and replays each
// one to the panel with setup, enable pulse, hold and execution-wait timing.
module lcd_write_ctrl #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2000,
    parameter int SLOW_CYC  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic [2:0] fifo_level,
    output logic       fifo_full,
    output logic       overflow,
    output logic       idle,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HE  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_4   = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
    localparam int MAX_ALL = (MAX_4 > SLOW_CYC) ? MAX_4 : SLOW_CYC;
    // The counter only ever holds a load value of (cycles - 1).
    localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LOAD  = CNT_W'(SLOW_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             slow;
    logic             pop;
    logic             push;
    logic [8:0]       fifo_mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic [8:0]       head;
    logic             head_slow;

    assign fifo_full  = (count == 3'd4);
    assign fifo_level = count;
    assign idle       = (state == S_IDLE) && (count == 3'd0);
    assign lcd_rw     = 1'b0;
    assign push       = wr_en && !fifo_full;
    assign head       = fifo_mem[rd_ptr];
    // Clear display and return home need the long execution wait.
    assign head_slow  = !head[8] && ((head[7:0] == 8'h01) || (head[7:0] == 8'h02));

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {wr_rs, wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (wr_en && fifo_full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            slow     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            lcd_e <= (next_state == S_PULSE);
            if (pop) begin
                lcd_rs   <= head[8];
                lcd_data <= head[7:0];
                slow     <= head_slow;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != 3'd0) begin
                    pop        = 1'b1;
                    next_state = S_SETUP;
                    next_cnt   = SETUP_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    next_state = S_PULSE;
                    next_cnt   = PULSE_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    next_state = S_HOLD;
                    next_cnt   = HOLD_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    next_state = S_WAIT;
                    next_cnt   = slow ? SLOW_LOAD : EXEC_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    next_state = S_IDLE;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: directed and random writes scored against a
// transfer-level model of queue occupancy and panel timing.
module tb_lcd_write_ctrl;

    localparam int S  = 3;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int E  = 6;
    localparam int SL = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic [2:0] fifo_level;
    logic       fifo_full;
    logic       overflow;
    logic       idle;
    logic       lcd_rs;
    logic       lcd_e;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] pending[$];
    logic [8:0] exp_q[$];
    logic [8:0] m_word;
    logic       m_ovf;
    int         edge_n;
    int         next_allowed;
    int         rise_edge;
    logic       prev_e;

    lcd_write_ctrl #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E), .SLOW_CYC(SL)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_rs(wr_rs), .wr_data(wr_data),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .overflow(overflow),
        .idle(idle), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endfunction

    function automatic bit model_idle();
        return (pending.size() == 0) && (edge_n >= next_allowed - 1);
    endfunction

    // Reference model: each accepted entry occupies the panel for the whole
    // setup+pulse+hold+wait span plus one idle cycle before the next may start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending.delete();
            exp_q.delete();
            m_ovf        = 1'b0;
            m_word       = 9'h000;
            edge_n       = 0;
            next_allowed = 0;
            rise_edge    = -1000;
        end else begin
            int  pre;
            bit  slow_w;
            logic [8:0] w;
            edge_n++;
            pre = pending.size();
            if (edge_n >= next_allowed && pre > 0) begin
                w = pending.pop_front();
                m_word = w;
                slow_w = !w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02);
                rise_edge = edge_n + S;
                next_allowed = edge_n + S + P + H + (slow_w ? SL : E) + 1;
            end
            if (wr_en) begin
                if (pre < 4) begin
                    pending.push_back({wr_rs, wr_data});
                    exp_q.push_back({wr_rs, wr_data});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every cycle and scores each enable pulse against the queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_e = 1'b0;
        end else begin
            checkOutput("fifo_level", 32'(fifo_level), 32'(pending.size()));
            checkOutput("fifo_full", 32'(fifo_full), 32'(pending.size() == 4));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("idle", 32'(idle), 32'(model_idle()));
            checkOutput("lcd_word", 32'({lcd_rs, lcd_data}), 32'(m_word));
            checkOutput("lcd_e", 32'(lcd_e), 32'(edge_n >= rise_edge && edge_n < rise_edge + P));
            checkOutput("lcd_rw", 32'(lcd_rw), 32'd0);
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL pulse_unexpected at edge %0d: got word %0h, expected no pulse",
                             edge_n, {lcd_rs, lcd_data});
                end else begin
                    checkOutput("pulse_word", 32'({lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
                end
            end
            prev_e = lcd_e;
        end
    end

    task automatic applyStimulus(input bit wr, input bit rs, input logic [7:0] data);
        @(negedge clk);
        wr_en   = wr;
        wr_rs   = rs;
        wr_data = data;
    endtask

    task automatic waitIdle(input int budget);
        bit done = 0;
        applyStimulus(0, 0, 8'h00);
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (model_idle()) done = 1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got busy after %0d cycles, expected idle", budget);
        end else begin
            checkOutput("drain_idle", 32'(idle), 32'd1);
            checkOutput("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        wr_en = 0; wr_rs = 0; wr_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_lcd_e", 32'(lcd_e), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_data", 32'(lcd_data), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        applyStimulus(1, 1, 8'h41);
        waitIdle(100);

        applyStimulus(1, 0, 8'h01);
        waitIdle(100);
        applyStimulus(1, 0, 8'h38);
        waitIdle(100);
        applyStimulus(1, 0, 8'h02);
        waitIdle(100);

        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 8'(8'h10 + i));
        waitIdle(300);

        // Six back-to-back writes: the sixth lands on a full queue and is dropped.
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 8'(8'hA0 + i));
        applyStimulus(0, 0, 8'h00);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        waitIdle(300);
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 8'h01 : 8'h02)
                                          : 8'($urandom);
            applyStimulus($urandom_range(99) < 35, $urandom_range(2) == 0, d);
        end
        waitIdle(600);

        // Reset in the middle of an enable pulse with entries still queued.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'(8'h60 + i));
        applyStimulus(0, 0, 8'h00);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (lcd_e) seen = 1;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL pulse_timeout: got no lcd_e, expected a pulse");
        end else begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1 checkOutput("async_e_drop", 32'(lcd_e), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            checkOutput("post_rst_level", 32'(fifo_level), 32'd0);
            checkOutput("post_rst_idle", 32'(idle), 32'd1);
            checkOutput("post_rst_overflow", 32'(overflow), 32'd0);
            checkOutput("post_rst_data", 32'(lcd_data), 32'd0);
            repeat (60) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_write_ctrl.md
# lcd_write_ctrl

Memory-mapped HD44780 character-LCD write sequencer for the MU0 FPGA system. It sits between the memory/peripheral decode block and the `lcd_*` output pads. CPU stores to the LCD address arrive as single-cycle write strobes and are queued in a 4-entry FIFO. Each entry is replayed to the panel with the required setup, enable-pulse, hold and execution-wait timing, so software never has to busy-wait.

## Interface
Parameters:
- `SETUP_CYC`, 4: cycles from rs/data valid to `lcd_e` rise (≥1).
- `PULSE_CYC`, 12: cycles `lcd_e` held high (≥1).
- `HOLD_CYC`, 4: cycles rs/data held after `lcd_e` fall (≥1).
- `EXEC_CYC`, 2000: post-transfer wait for ordinary commands and data (≥1).
- `SLOW_CYC`, 82000: post-transfer wait for clear/home (rs=0, data 0x01 or 0x02) (≥1; counter width sized to the maximum of EXEC_CYC and SLOW_CYC).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: system clock.
  - `rst`, in, 1: asynchronous active-high reset.
- Write side:
  - `wr_en`, in, 1: one-cycle write strobe from address decode.
  - `wr_rs`, in, 1: register select for the write (0 = command, 1 = data).
  - `wr_data`, in, 8: byte to send.
- Status:
  - `fifo_level`, out, 3: number of queued entries, 0 to 4.
  - `fifo_full`, out, 1: high when `fifo_level` is 4.
  - `overflow`, out, 1: sticky; set when a write is dropped.
  - `idle`, out, 1: high when the FIFO is empty and the FSM is in IDLE.
- Panel side:
  - `lcd_rs`, out, 1.
  - `lcd_e`, out, 1.
  - `lcd_rw`, out, 1: tied to 0 (write-only).
  - `lcd_data`, out, 8.

## Operation
- FIFO: 4 entries of 9 bits {rs, data}, with 2-bit wrapping read and write pointers and a 3-bit count.
  - Push on `wr_en` when not full.
  - If `wr_en` arrives while full, drop the write and set `overflow`. `overflow` clears only on `rst`.
  - Push and pop in the same cycle: both take effect and the level is unchanged.
  - A push into a full FIFO is dropped even if a pop occurs in that same cycle.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. A single down-counter `cnt` times all states.
  - IDLE: if the FIFO is not empty, pop, latch {rs, data} into the `lcd_rs`/`lcd_data` registers, set `cnt`=SETUP_CYC-1, and go to SETUP. Also latch `slow` = (rs==0 && data∈{0x01,0x02}).
  - SETUP: when `cnt`==0, go to PULSE with `cnt`=PULSE_CYC-1. Otherwise decrement.
  - PULSE: `lcd_e`=1. When `cnt`==0, go to HOLD with `cnt`=HOLD_CYC-1.
  - HOLD: `lcd_e`=0 and rs/data held. When `cnt`==0, go to WAIT with `cnt`=(`slow` ? SLOW_CYC : EXEC_CYC)-1.
  - WAIT: when `cnt`==0, go to IDLE. `lcd_rs`/`lcd_data` keep their last values until the next pop.
- `lcd_e` is a registered output, high exactly when state is PULSE.
- Status outputs are derived from registered state only.
- Reset: state IDLE, FIFO empty, `cnt`=0, `slow`=0. All outputs are 0 during and after reset, except `idle`, which is 1 after reset.
- Reset mid-transfer: `lcd_e` drops asynchronously and queued entries are discarded.

## Timing
- `wr_en` sampled at edge N:
  - Entry is visible in `fifo_level` after edge N.
  - If the block was idle, the pop occurs at edge N+1 and `lcd_data`/`lcd_rs` are valid after N+1.
- `lcd_e` rises after edge N+1+SETUP_CYC.
- `lcd_e` stays high for PULSE_CYC cycles.
- `lcd_e` falls, then data is held for HOLD_CYC cycles.
- The FSM re-enters IDLE after WAIT_CYC more cycles.
- Per-entry occupancy is SETUP+PULSE+HOLD+WAIT cycles plus 1 IDLE cycle. Back-to-back entries are therefore spaced SETUP+PULSE+HOLD+WAIT+1 cycles apart.
- `idle` goes high in the first cycle that is IDLE with an empty FIFO.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-PULSE. Required: `lcd_e` goes 0 immediately; after release `fifo_level`=0, `idle`=1, `overflow`=0, `lcd_data`=0x00.
- **Single data write:** `wr_rs`=1, `wr_data`=0x41 at edge 0. Required: `lcd_data`=0x41 and `lcd_rs`=1 after edge 1; `lcd_e` high during cycles 6–17 (defaults); `idle`=1 again at cycle 2022.
- **Clear command:** `wr_rs`=0, `wr_data`=0x01. Required: WAIT lasts 82000 cycles. Repeat with 0x38 and require 2000 cycles.
- **Burst of four:** four writes on four consecutive edges (0x10–0x13) while idle. Required: `fifo_level` sequence 1, 1, 2, 3 (the first entry pops immediately); panel receives 0x10, 0x11, 0x12, 0x13 in order, each with an `lcd_e` pulse spaced 2021 cycles apart.
- **Overflow:** six writes on consecutive cycles while busy. Required: `fifo_full`=1 at level 4, the excess write is dropped, `overflow`=1 and stays set, and the dropped byte never appears on `lcd_data`.
- **Simultaneous push/pop:** `wr_en` in the same cycle as the IDLE pop with level 1. Required: level stays 1 and the new entry is sent next.
